// File: rtl/nios_system_timer_master.sv
// nios_system_timer_master
// Avalon-MM initiator for the system interval timer s1 port. Programs the
// period, starts the timer in continuous mode with its IRQ enabled, and
// clears each timeout, turning every serviced timeout into a tick pulse and
// a wrapping tick count for fabric logic.
//
// Optional build macro: NIOS_SYSTEM_TIMER_MASTER_SNAPSHOT_EN
//   When defined, every serviced timeout is followed by a snapshot of the
//   timer counter (snap_value / snap_valid outputs).
//
// Bus outputs are decoded from the state register, so an asynchronous
// reset drops chipselect in the same instant the state returns to IDLE.
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | timer stopped, waiting for enable
// WR_PL      | write period low half   (addr 2)
// WR_PH      | write period high half  (addr 3)
// WR_CTRL    | write ITO|CONT|START    (addr 1)
// WAIT_IRQ   | bus idle, waiting for timeout or enable drop
// CLR_TO     | clear timeout status    (addr 0), tick pulse
// WR_STOP    | write STOP with IRQ off (addr 1)
// SNAP_WR    | latch timer counter     (addr 4)            [snapshot]
// SNAP_RDL   | read snapshot low       (addr 4)            [snapshot]
// SNAP_RDH   | read snapshot high      (addr 5)            [snapshot]
// SNAP_DONE  | capture high half, snap_valid pulse         [snapshot]

module nios_system_timer_master #(
    parameter logic [31:0] PERIOD = 32'h1DCD64FF,
    parameter int          TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              irq,
    input  logic [15:0]       readdata,
    output logic [2:0]        address,
    output logic              chipselect,
    output logic              write_n,
    output logic [15:0]       writedata,
    output logic              busy,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count
`ifdef NIOS_SYSTEM_TIMER_MASTER_SNAPSHOT_EN
    ,
    output logic [31:0]       snap_value,
    output logic              snap_valid
`endif
);

    localparam logic [15:0] CTRL_START = 16'h0007;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        WAIT_IRQ,
        CLR_TO,
        WR_STOP
`ifdef NIOS_SYSTEM_TIMER_MASTER_SNAPSHOT_EN
        ,
        SNAP_WR,
        SNAP_RDL,
        SNAP_RDH,
        SNAP_DONE
`endif
    } state_t;

    state_t state;
    state_t next_state;
    // High during the first WAIT_IRQ cycle: the timer drops irq one cycle
    // after the status clear, so that cycle's irq must not be trusted.
    logic   settle;

    // State register and irq settle guard
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            settle <= 1'b0;
        end else begin
            state  <= next_state;
            settle <= (next_state == WAIT_IRQ) && (state != WAIT_IRQ);
        end
    end

    // Serviced-timeout counter, wraps silently
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_count <= '0;
        end else if (state == CLR_TO) begin
            tick_count <= tick_count + TICK_W'(1);
        end
    end

    // Next-state and bus/status decode
    always_comb begin
        next_state = state;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0000;
        busy       = 1'b1;
        tick       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (enable) next_state = WR_PL;
            end
            WR_PL: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = 3'd2;
                writedata  = PERIOD[15:0];
                next_state = WR_PH;
            end
            WR_PH: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = 3'd3;
                writedata  = PERIOD[31:16];
                next_state = WR_CTRL;
            end
            WR_CTRL: begin
                // Must follow WR_PH directly: the start lands on the timer's
                // forced reload and wins over it.
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = 3'd1;
                writedata  = CTRL_START;
                next_state = WAIT_IRQ;
            end
            WAIT_IRQ: begin
                busy = 1'b0;
                if (!enable) begin
                    next_state = WR_STOP;
                end else if (irq && !settle) begin
                    next_state = CLR_TO;
                end
            end
            CLR_TO: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = 3'd0;
                writedata  = 16'h0000;
                tick       = 1'b1;
`ifdef NIOS_SYSTEM_TIMER_MASTER_SNAPSHOT_EN
                next_state = SNAP_WR;
`else
                next_state = WAIT_IRQ;
`endif
            end
            WR_STOP: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = 3'd1;
                writedata  = CTRL_STOP;
                next_state = IDLE;
            end
`ifdef NIOS_SYSTEM_TIMER_MASTER_SNAPSHOT_EN
            SNAP_WR: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = 3'd4;
                next_state = SNAP_RDL;
            end
            SNAP_RDL: begin
                chipselect = 1'b1;
                address    = 3'd4;
                next_state = SNAP_RDH;
            end
            SNAP_RDH: begin
                chipselect = 1'b1;
                address    = 3'd5;
                next_state = SNAP_DONE;
            end
            SNAP_DONE: begin
                next_state = WAIT_IRQ;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

`ifdef NIOS_SYSTEM_TIMER_MASTER_SNAPSHOT_EN
    logic [31:0] snap_reg;

    // Capture the two read halves as they arrive one cycle after each address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_reg <= 32'h0;
        end else if (state == SNAP_RDH) begin
            snap_reg[15:0] <= readdata;
        end else if (state == SNAP_DONE) begin
            snap_reg[31:16] <= readdata;
        end
    end

    // High half is forwarded live in SNAP_DONE so the value is whole during the pulse
    always_comb begin
        snap_valid = (state == SNAP_DONE);
        snap_value = snap_valid ? {readdata, snap_reg[15:0]} : snap_reg;
    end
`else
    logic unused_readdata;
    assign unused_readdata = ^readdata;
`endif

endmodule
